// File: rtl/cv32e40p_if_id_pkg.sv
// Shared IF-ID buffer types: buffered entry layout and the default buffer depth.
package cv32e40p_if_id_pkg;

    localparam int unsigned IF_ID_DEPTH = 2;
    localparam int unsigned IF_ID_ILEN  = 32;

    typedef struct packed {
        logic [IF_ID_ILEN-1:0] instr;
        logic [IF_ID_ILEN-1:0] pc;
        logic                  compressed;
        logic                  illegal_c;
    } if_id_entry_t;

endpackage

// File: rtl/cv32e40p_if_id_buffer.sv
// Small FIFO between the fetch stage and ID. The head entry is held in output
// registers, so nothing passes combinationally from in_* to out_*.
module cv32e40p_if_id_buffer
    import cv32e40p_if_id_pkg::*;
#(
    parameter int unsigned DEPTH = IF_ID_DEPTH,
    parameter int unsigned ILEN  = IF_ID_ILEN
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid_i,
    input  logic [ILEN-1:0]              in_instr_i,
    input  logic [ILEN-1:0]              in_pc_i,
    input  logic                         in_compressed_i,
    input  logic                         in_illegal_c_i,
    input  logic                         fetch_failed_i,
    input  logic                         halt_if_i,
    input  logic                         flush_i,
    output logic                         in_ready_o,
    output logic                         out_valid_o,
    output logic [ILEN-1:0]              out_instr_o,
    output logic [ILEN-1:0]              out_pc_o,
    output logic                         out_compressed_o,
    output logic                         out_illegal_c_o,
    output logic                         out_fetch_failed_o,
    input  logic                         id_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // The entry struct is sized by the package; a mismatched ILEN would truncate.
    if (ILEN != IF_ID_ILEN) begin : g_ilen_check
        $error("cv32e40p_if_id_buffer: ILEN must equal IF_ID_ILEN");
    end

    if_id_entry_t     r_mem [DEPTH];
    if_id_entry_t     r_head;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W-1:0] r_wptr;
    logic [CNT_W-1:0] r_count;
    logic             r_fetch_failed;

    if_id_entry_t     w_in_entry;
    if_id_entry_t     w_head_nxt;
    logic [PTR_W-1:0] w_rptr_nxt;
    logic [PTR_W-1:0] w_wptr_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_fetch_failed_nxt;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign in_ready_o = (r_count < CNT_W'(DEPTH)) & ~halt_if_i;

    // Next-state: pointers, occupancy, sticky status and the next head entry.
    always_comb begin
        w_in_entry = '{instr:      IF_ID_ILEN'(in_instr_i),
                       pc:         IF_ID_ILEN'(in_pc_i),
                       compressed: in_compressed_i,
                       illegal_c:  in_illegal_c_i};
        w_push             = in_valid_i & in_ready_o & ~flush_i;
        w_pop              = (r_count != '0) & id_ready_i & ~flush_i;
        w_rptr_nxt         = r_rptr;
        w_wptr_nxt         = r_wptr;
        w_count_nxt        = r_count;
        w_fetch_failed_nxt = r_fetch_failed;
        w_head_nxt         = r_head;

        if (flush_i) begin
            w_rptr_nxt         = '0;
            w_wptr_nxt         = '0;
            w_count_nxt        = '0;
            w_fetch_failed_nxt = fetch_failed_i;
        end else begin
            if (w_push) begin
                w_wptr_nxt         = ptr_inc(r_wptr);
                w_fetch_failed_nxt = 1'b0;
            end
            if (w_pop) begin
                w_rptr_nxt = ptr_inc(r_rptr);
            end
            if (w_push && !w_pop) begin
                w_count_nxt = r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                w_count_nxt = r_count - CNT_W'(1);
            end
            // A new head appears after a pop or when an empty buffer is filled;
            // it may be the entry being written on this very edge.
            if ((w_count_nxt != '0) && (w_pop || (r_count == '0))) begin
                w_head_nxt = (w_push && (r_wptr == w_rptr_nxt)) ? w_in_entry
                                                                : r_mem[w_rptr_nxt];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_head         <= '0;
            r_rptr         <= '0;
            r_wptr         <= '0;
            r_count        <= '0;
            r_fetch_failed <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_in_entry;
            end
            r_head         <= w_head_nxt;
            r_rptr         <= w_rptr_nxt;
            r_wptr         <= w_wptr_nxt;
            r_count        <= w_count_nxt;
            r_fetch_failed <= w_fetch_failed_nxt;
        end
    end

    assign out_valid_o        = (r_count != '0);
    assign out_instr_o        = ILEN'(r_head.instr);
    assign out_pc_o           = ILEN'(r_head.pc);
    assign out_compressed_o   = r_head.compressed;
    assign out_illegal_c_o    = r_head.illegal_c;
    assign out_fetch_failed_o = r_fetch_failed;
    assign count_o            = r_count;

endmodule

// File: tb/tb_cv32e40p_if_id_buffer.sv
// Scoreboard bench for the IF-ID buffer: DEPTH=2 directed cases and a DEPTH=3 wrap stream.
module tb_cv32e40p_if_id_buffer;
    import cv32e40p_if_id_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // DEPTH=2 instance signals
    logic        a_in_valid, a_comp, a_ill, a_ff_in, a_halt, a_flush, a_id_ready;
    logic [31:0] a_instr, a_pc;
    logic        a_in_ready, a_out_valid, a_out_comp, a_out_ill, a_out_ff;
    logic [31:0] a_out_instr, a_out_pc;
    logic [1:0]  a_count;

    // DEPTH=3 instance signals
    logic        b_in_valid, b_comp, b_ill, b_ff_in, b_halt, b_flush, b_id_ready;
    logic [31:0] b_instr, b_pc;
    logic        b_in_ready, b_out_valid, b_out_comp, b_out_ill, b_out_ff;
    logic [31:0] b_out_instr, b_out_pc;
    logic [1:0]  b_count;

    if_id_entry_t qa[$];
    if_id_entry_t qb[$];
    int           b_popped = 0;

    cv32e40p_if_id_buffer #(.DEPTH(2), .ILEN(32)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(a_in_valid), .in_instr_i(a_instr), .in_pc_i(a_pc),
        .in_compressed_i(a_comp), .in_illegal_c_i(a_ill),
        .fetch_failed_i(a_ff_in), .halt_if_i(a_halt), .flush_i(a_flush),
        .in_ready_o(a_in_ready), .out_valid_o(a_out_valid),
        .out_instr_o(a_out_instr), .out_pc_o(a_out_pc),
        .out_compressed_o(a_out_comp), .out_illegal_c_o(a_out_ill),
        .out_fetch_failed_o(a_out_ff), .id_ready_i(a_id_ready), .count_o(a_count)
    );

    cv32e40p_if_id_buffer #(.DEPTH(3), .ILEN(32)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(b_in_valid), .in_instr_i(b_instr), .in_pc_i(b_pc),
        .in_compressed_i(b_comp), .in_illegal_c_i(b_ill),
        .fetch_failed_i(b_ff_in), .halt_if_i(b_halt), .flush_i(b_flush),
        .in_ready_o(b_in_ready), .out_valid_o(b_out_valid),
        .out_instr_o(b_out_instr), .out_pc_o(b_out_pc),
        .out_compressed_o(b_out_comp), .out_illegal_c_o(b_out_ill),
        .out_fetch_failed_o(b_out_ff), .id_ready_i(b_id_ready), .count_o(b_count)
    );

    // Instruction payload tied to the PC so order errors show up in every field.
    function automatic if_id_entry_t mk(input logic [31:0] pc);
        if_id_entry_t e;
        e.pc         = pc;
        e.instr      = 32'h0000_0013 | ((pc - 32'h80) << 10);
        e.compressed = pc[2];
        e.illegal_c  = pc[3];
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic offer_a(input logic [31:0] pc);
        if_id_entry_t e;
        e          = mk(pc);
        a_in_valid = 1'b1;
        a_pc       = e.pc;
        a_instr    = e.instr;
        a_comp     = e.compressed;
        a_ill      = e.illegal_c;
    endtask

    task automatic offer_b(input logic [31:0] pc);
        if_id_entry_t e;
        e          = mk(pc);
        b_in_valid = 1'b1;
        b_pc       = e.pc;
        b_instr    = e.instr;
        b_comp     = e.compressed;
        b_ill      = e.illegal_c;
    endtask

    // Monitors: every consumed head must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && a_out_valid && a_id_ready && !a_flush) begin
            if (qa.size() == 0) begin
                chk("a_pop_unexpected", {32'h0, a_out_pc}, 64'hFFFF_FFFF);
            end else begin
                if_id_entry_t e;
                e = qa.pop_front();
                chk("a_pop_pc", {32'h0, a_out_pc}, {32'h0, e.pc});
                chk("a_pop_instr", {30'h0, a_out_instr, a_out_comp, a_out_ill},
                    {30'h0, e.instr, e.compressed, e.illegal_c});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_out_valid && b_id_ready && !b_flush) begin
            if (qb.size() == 0) begin
                chk("b_pop_unexpected", {32'h0, b_out_pc}, 64'hFFFF_FFFF);
            end else begin
                if_id_entry_t e;
                e = qb.pop_front();
                b_popped++;
                chk("b_pop_pc", {32'h0, b_out_pc}, {32'h0, e.pc});
                chk("b_pop_instr", {30'h0, b_out_instr, b_out_comp, b_out_ill},
                    {30'h0, e.instr, e.compressed, e.illegal_c});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        {a_in_valid, a_comp, a_ill, a_ff_in, a_halt, a_flush, a_id_ready} = '0;
        {b_in_valid, b_comp, b_ill, b_ff_in, b_halt, b_flush, b_id_ready} = '0;
        a_instr = '0; a_pc = '0; b_instr = '0; b_pc = '0;
        #12;
        chk("rst_count", 64'(a_count), 64'd0);
        chk("rst_valid", 64'(a_out_valid), 64'd0);
        chk("rst_pc", 64'(a_out_pc), 64'd0);
        chk("rst_instr", 64'(a_out_instr), 64'd0);
        chk("rst_ff", 64'(a_out_ff), 64'd0);
        chk("rst_ready", 64'(a_in_ready), 64'd1);
        a_halt = 1'b1;
        #1;
        chk("rst_ready_halt", 64'(a_in_ready), 64'd0);
        a_halt = 1'b0;
        rst_n  = 1'b1;
        cyc();

        // single push appears one cycle later
        offer_a(32'h80); qa.push_back(mk(32'h80));
        cyc();
        a_in_valid = 1'b0;
        chk("push1_count", 64'(a_count), 64'd1);
        chk("push1_valid", 64'(a_out_valid), 64'd1);
        chk("push1_pc", 64'(a_out_pc), 64'h80);
        chk("push1_instr", 64'(a_out_instr), 64'h13);

        // fill, refuse third offer, then a single pop
        offer_a(32'h84); qa.push_back(mk(32'h84));
        cyc();
        offer_a(32'h88);
        chk("full_count", 64'(a_count), 64'd2);
        chk("full_ready", 64'(a_in_ready), 64'd0);
        cyc();
        chk("full_hold_count", 64'(a_count), 64'd2);
        a_in_valid = 1'b0;
        a_id_ready = 1'b1;
        cyc();
        a_id_ready = 1'b0;
        chk("pop1_pc", 64'(a_out_pc), 64'h84);
        chk("pop1_count", 64'(a_count), 64'd1);
        offer_a(32'h88); qa.push_back(mk(32'h88));
        cyc();
        a_in_valid = 1'b0;
        chk("refill_count", 64'(a_count), 64'd2);

        // flush with a concurrent offer and fetch failure
        a_flush = 1'b1; a_ff_in = 1'b1; offer_a(32'h8C);
        cyc();
        qa.delete();
        a_flush = 1'b0; a_ff_in = 1'b0; a_in_valid = 1'b0;
        chk("flush_count", 64'(a_count), 64'd0);
        chk("flush_valid", 64'(a_out_valid), 64'd0);
        chk("flush_ff", 64'(a_out_ff), 64'd1);
        cyc();
        chk("ff_hold", 64'(a_out_ff), 64'd1);
        offer_a(32'h90); qa.push_back(mk(32'h90));
        cyc();
        a_in_valid = 1'b0;
        chk("ff_clear", 64'(a_out_ff), 64'd0);
        chk("post_flush_pc", 64'(a_out_pc), 64'h90);
        chk("post_flush_count", 64'(a_count), 64'd1);

        // halt blocks acceptance but pops proceed
        a_halt = 1'b1; offer_a(32'h94); a_id_ready = 1'b1;
        #1;
        chk("halt_ready", 64'(a_in_ready), 64'd0);
        cyc();
        a_id_ready = 1'b0;
        chk("halt_pop_count", 64'(a_count), 64'd0);
        cyc();
        chk("halt_idle_count", 64'(a_count), 64'd0);
        chk("empty_hold_pc", 64'(a_out_pc), 64'h90);
        a_halt = 1'b0; a_in_valid = 1'b0;

        // simultaneous push and pop keeps occupancy
        offer_a(32'hA0); qa.push_back(mk(32'hA0));
        cyc();
        offer_a(32'hA4); qa.push_back(mk(32'hA4)); a_id_ready = 1'b1;
        cyc();
        a_id_ready = 1'b0;
        chk("pushpop_count", 64'(a_count), 64'd1);
        chk("pushpop_pc", 64'(a_out_pc), 64'hA4);
        offer_a(32'hA8); qa.push_back(mk(32'hA8));
        cyc();
        a_in_valid = 1'b0;
        chk("prereset_count", 64'(a_count), 64'd2);

        // asynchronous reset mid-operation
        #1 rst_n = 1'b0;
        #1;
        qa.delete();
        chk("arst_count", 64'(a_count), 64'd0);
        chk("arst_valid", 64'(a_out_valid), 64'd0);
        chk("arst_pc", 64'(a_out_pc), 64'd0);
        chk("arst_instr", 64'(a_out_instr), 64'd0);
        chk("arst_flags", 64'({a_out_comp, a_out_ill, a_out_ff}), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("arst_ready", 64'(a_in_ready), 64'd1);
        cyc();
        chk("arst_after_count", 64'(a_count), 64'd0);

        // DEPTH=3 stream of 10 PCs, pointers wrap several times
        for (int i = 0; i < 10; i++) begin
            offer_b(32'h80 + 32'(i * 4)); qb.push_back(mk(32'h80 + 32'(i * 4)));
            if (i == 2) b_id_ready = 1'b1;
            cyc();
        end
        b_in_valid = 1'b0;
        chk("b_stream_count", 64'(b_count), 64'd2);
        for (int k = 0; k < 10 && b_out_valid; k++) begin
            cyc();
        end
        b_id_ready = 1'b0;
        chk("b_drain_count", 64'(b_count), 64'd0);
        chk("b_popped", 64'(b_popped), 64'd10);
        chk("b_queue_left", 64'(qb.size()), 64'd0);
        chk("a_queue_left", 64'(qa.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
